// File: rtl/pll_freq_ctrl.sv
// pll_freq_ctrl: reset, relock and divider-select sequencer for a dynamic-IDSEL rPLL.
// Ports:
//   clk, rst_n            board clock (also the PLL input) and synchronous active-low reset
//   req_valid, req_idsel  frequency change request and its 6-bit divider code
//   req_ready             a request is accepted this cycle (READY or FAIL)
//   pll_lock              raw PLL lock, asynchronous to clk
//   pll_reset, pll_idsel  PLL reset (active-high) and divider code
//   clk_ready             PLL output stable and usable
//   err_timeout           sticky: retries exhausted, sequencer parked in FAIL
//   lock_lost             sticky: lock dropped while READY
module pll_freq_ctrl #(
    parameter int         RESET_CYCLES  = 16,
    parameter int         LOCK_TIMEOUT  = 27000,
    parameter int         LOCK_STABLE   = 256,
    parameter int         MAX_RETRIES   = 3,
    parameter logic [5:0] DEFAULT_IDSEL = 6'd63
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic [5:0] req_idsel,
    output logic       req_ready,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic [5:0] pll_idsel,
    output logic       clk_ready,
    output logic       err_timeout,
    output logic       lock_lost
);
    localparam int MAX_A = RESET_CYCLES > LOCK_STABLE ? RESET_CYCLES : LOCK_STABLE;
    localparam int MAX_C = LOCK_TIMEOUT > MAX_A ? LOCK_TIMEOUT : MAX_A;
    localparam int CW = $clog2(MAX_C + 1);
    localparam int RW = $clog2(MAX_RETRIES + 1);
    localparam logic [CW-1:0] RST_END = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] TO_END  = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STB_END = CW'(LOCK_STABLE - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

    typedef enum logic [2:0] {S_RESET_PLL, S_WAIT_LOCK, S_STABLE, S_READY, S_FAIL} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [RW-1:0] retry, retry_n, retry_inc;
    logic [5:0]    idsel_n;
    logic          err_n, lost_n, accept, sync1, lock_s;

    always_comb begin
        accept    = req_valid && req_ready;
        retry_inc = retry + RW'(1);
        state_n   = state;
        cnt_n     = cnt + CW'(1);
        retry_n   = retry;
        idsel_n   = pll_idsel;
        err_n     = err_timeout;
        lost_n    = lock_lost;
        // An accepted request overrides everything, including a same-cycle lock loss.
        if (accept) begin
            state_n = S_RESET_PLL;
            cnt_n   = '0;
            retry_n = '0;
            idsel_n = req_idsel;
            err_n   = 1'b0;
            lost_n  = 1'b0;
        end else begin
            case (state)
                S_RESET_PLL: if (cnt == RST_END) begin
                    state_n = S_WAIT_LOCK;
                    cnt_n   = '0;
                end
                S_WAIT_LOCK: if (lock_s) begin
                    state_n = S_STABLE;
                    cnt_n   = '0;
                end else if (cnt == TO_END) begin
                    retry_n = retry_inc;
                    state_n = retry_inc == RETRY_MAX ? S_FAIL : S_RESET_PLL;
                    err_n   = err_timeout | (retry_inc == RETRY_MAX);
                    cnt_n   = '0;
                end
                // A dropout during qualification restarts the timeout window without costing a retry.
                S_STABLE: if (!lock_s) begin
                    state_n = S_WAIT_LOCK;
                    cnt_n   = '0;
                end else if (cnt == STB_END) begin
                    state_n = S_READY;
                    cnt_n   = '0;
                end
                S_READY: begin
                    cnt_n = '0;
                    if (!lock_s) begin
                        state_n = S_RESET_PLL;
                        retry_n = '0;
                        lost_n  = 1'b1;
                    end
                end
                S_FAIL: cnt_n = '0;
                default: begin
                    state_n = S_RESET_PLL;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1       <= 1'b0;
            lock_s      <= 1'b0;
            state       <= S_RESET_PLL;
            cnt         <= '0;
            retry       <= '0;
            pll_idsel   <= DEFAULT_IDSEL;
            err_timeout <= 1'b0;
            lock_lost   <= 1'b0;
            pll_reset   <= 1'b1;
            clk_ready   <= 1'b0;
            req_ready   <= 1'b0;
        end else begin
            sync1       <= pll_lock;
            lock_s      <= sync1;
            state       <= state_n;
            cnt         <= cnt_n;
            retry       <= retry_n;
            pll_idsel   <= idsel_n;
            err_timeout <= err_n;
            lock_lost   <= lost_n;
            pll_reset   <= state_n == S_RESET_PLL || state_n == S_FAIL;
            clk_ready   <= state_n == S_READY;
            req_ready   <= state_n == S_READY || state_n == S_FAIL;
        end
    end
endmodule

// File: tb/tb_pll_freq_ctrl.sv
// tb_pll_freq_ctrl: directed self-checking bench for pll_freq_ctrl with small timing parameters.
module tb_pll_freq_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic [5:0] req_idsel = 6'd0;
    logic       pll_lock = 1'b0;
    logic       req_ready, pll_reset, clk_ready, err_timeout, lock_lost;
    logic [5:0] pll_idsel;
    int         checks = 0;
    int         failures = 0;

    pll_freq_ctrl #(
        .RESET_CYCLES(4),
        .LOCK_TIMEOUT(64),
        .LOCK_STABLE(8),
        .MAX_RETRIES(2),
        .DEFAULT_IDSEL(6'd63)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_idsel(req_idsel),
        .req_ready(req_ready),
        .pll_lock(pll_lock),
        .pll_reset(pll_reset),
        .pll_idsel(pll_idsel),
        .clk_ready(clk_ready),
        .err_timeout(err_timeout),
        .lock_lost(lock_lost)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Comments [eN] mark the negedge following rising edge N after reset release.
    initial begin
        step(3);
        chk("rst_pll_reset", pll_reset, 1);
        chk("rst_idsel", pll_idsel, 63);
        chk("rst_clk_ready", clk_ready, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_lost", lock_lost, 0);
        rst_n = 1'b1;
        step(1); chk("pu_reset_e1", pll_reset, 1);
        step(2); chk("pu_reset_e3", pll_reset, 1);
        step(1); chk("pu_reset_e4", pll_reset, 0);
        chk("pu_idsel", pll_idsel, 63);
        step(19); pll_lock = 1'b1;
        step(10); chk("pu_ready_e33", clk_ready, 0);
        step(1); chk("pu_ready_e34", clk_ready, 1);
        chk("pu_req_ready", req_ready, 1);
        chk("pu_idsel_ready", pll_idsel, 63);
        req_valid = 1'b1; req_idsel = 6'd60;
        step(1);
        chk("req_idsel", pll_idsel, 60);
        chk("req_reset", pll_reset, 1);
        chk("req_clk_ready", clk_ready, 0);
        chk("req_req_ready", req_ready, 0);
        req_valid = 1'b0; pll_lock = 1'b0;
        step(3); chk("req_reset_e38", pll_reset, 1);
        step(1); chk("req_reset_e39", pll_reset, 0);
        pll_lock = 1'b1;
        step(10); chk("relock_e49", clk_ready, 0);
        step(1); chk("relock_e50", clk_ready, 1);
        chk("relock_err", err_timeout, 0);
        pll_lock = 1'b0;
        step(2); chk("drop_ready_e52", clk_ready, 1);
        chk("drop_lost_e52", lock_lost, 0);
        step(1); chk("drop_ready_e53", clk_ready, 0);
        chk("drop_reset_e53", pll_reset, 1);
        chk("drop_lost_e53", lock_lost, 1);
        step(3); chk("drop_reset_e56", pll_reset, 1);
        step(1); chk("drop_reset_e57", pll_reset, 0);
        step(3); pll_lock = 1'b1;
        step(11); chk("drop_relock", clk_ready, 1);
        chk("drop_lost_sticky", lock_lost, 1);
        req_valid = 1'b1; req_idsel = 6'd61;
        step(1); chk("glitch_req_lost", lock_lost, 0);
        chk("glitch_req_idsel", pll_idsel, 61);
        req_valid = 1'b0;
        step(8); pll_lock = 1'b0;
        step(1); pll_lock = 1'b1;
        step(2); chk("glitch_reset_e83", pll_reset, 0);
        chk("glitch_ready_e83", clk_ready, 0);
        step(8); chk("glitch_ready_e91", clk_ready, 0);
        step(1); chk("glitch_ready_e92", clk_ready, 1);
        pll_lock = 1'b0; req_valid = 1'b1; req_idsel = 6'd62;
        step(1); chk("to_idsel", pll_idsel, 62);
        req_valid = 1'b0;
        step(4); chk("to_w1_start", pll_reset, 0);
        step(63); chk("to_w1_end", pll_reset, 0);
        step(1); chk("to_retry_reset", pll_reset, 1);
        chk("to_retry_err", err_timeout, 0);
        step(3); chk("to_retry_reset_e164", pll_reset, 1);
        step(1); chk("to_w2_start", pll_reset, 0);
        step(63); chk("to_w2_end", pll_reset, 0);
        chk("to_w2_err", err_timeout, 0);
        chk("to_w2_req_ready", req_ready, 0);
        step(1); chk("fail_reset", pll_reset, 1);
        chk("fail_err", err_timeout, 1);
        chk("fail_req_ready", req_ready, 1);
        chk("fail_clk_ready", clk_ready, 0);
        step(10); chk("fail_hold_err", err_timeout, 1);
        chk("fail_hold_reset", pll_reset, 1);
        req_valid = 1'b1; req_idsel = 6'd60;
        step(1); chk("fail_req_err", err_timeout, 0);
        chk("fail_req_idsel", pll_idsel, 60);
        chk("fail_req_reset", pll_reset, 1);
        chk("fail_req_req_ready", req_ready, 0);
        req_idsel = 6'd5;
        step(2); chk("ignored_req_idsel", pll_idsel, 60);
        req_valid = 1'b0;
        step(2); chk("ignored_req_reset", pll_reset, 0);
        step(6); chk("mid_wait_reset", pll_reset, 0);
        chk("mid_wait_idsel", pll_idsel, 60);
        rst_n = 1'b0;
        step(1); chk("midrst_idsel", pll_idsel, 63);
        chk("midrst_reset", pll_reset, 1);
        chk("midrst_err", err_timeout, 0);
        chk("midrst_lost", lock_lost, 0);
        chk("midrst_clk_ready", clk_ready, 0);
        chk("midrst_req_ready", req_ready, 0);
        rst_n = 1'b1; req_valid = 1'b1; req_idsel = 6'd10;
        step(3); chk("rstpll_req_idsel", pll_idsel, 63);
        chk("rstpll_req_reset", pll_reset, 1);
        step(1); chk("rstpll_req_fall", pll_reset, 0);
        chk("rstpll_req_idsel2", pll_idsel, 63);
        req_valid = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
